sici_rx_frame_sync: RTL and testbench



---
 rtl/sici_rx_frame_sync.sv | 205 ++++++++++++++++++++
 tb/tb_sici_rx_frame_sync.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sici_rx_frame_sync.sv
// -----------------------------------------------------------------------------
// sici_rx_frame_sync
//
// Receive-side PCS frame synchronizer for the sici link (77.76 MHz parallel
// domain). It sits between the SERDES deserializer and the receive
// descrambler/deframer. It checks the 2-bit sync header (SH) at the top of every
// FW-bit word. Until header alignment is found, it issues one-cycle bit-slip
// requests to the deserializer. Lock and loss of lock use hysteresis, and the
// aligned payload is forwarded downstream.
//
// Ports
//   Ck_77       in   1            the only clock
//   Rs          in   1            asynchronous, active-high reset
//   Rx_Phy_Dat  in   FW           deserialized word, [FW-1:FW-2] = SH
//   Rx_Re_Syn   in   1            forced resync (level, top priority)
//   Rx_Bit_Slp  out  1            one-cycle slip request to the deserializer
//   Rx_Dat      out  FW-2         payload of the previous word
//   Rx_Dat_SH   out  2            SH of the word on Rx_Dat
//   Rx_Dat_Vld  out  1            Rx_Dat/Rx_Dat_SH valid (LOCK only)
//   Rx_Lo_Syn   out  1            loss-of-sync, low only while in LOCK
//   Rx_Err_SH   out  1            pulse per invalid SH seen in CHECK or LOCK
//   Rx_Slp_Pos  out  $clog2(FW)   slips issued, modulo FW (debug)
// -----------------------------------------------------------------------------
module sici_rx_frame_sync #(
    parameter int FW        = 8,
    parameter int LOCK_CNT  = 64,
    parameter int SWT       = 64,
    parameter int BAD_MAX   = 16,
    parameter int SLIP_WAIT = 4
) (
    input  logic                  Ck_77,
    input  logic                  Rs,
    input  logic [FW-1:0]         Rx_Phy_Dat,
    input  logic                  Rx_Re_Syn,
    output logic                  Rx_Bit_Slp,
    output logic [FW-3:0]         Rx_Dat,
    output logic [1:0]            Rx_Dat_SH,
    output logic                  Rx_Dat_Vld,
    output logic                  Rx_Lo_Syn,
    output logic                  Rx_Err_SH,
    output logic [$clog2(FW)-1:0] Rx_Slp_Pos
);

    localparam int POS_W  = $clog2(FW);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = (SWT > 1) ? $clog2(SWT) : 1;
    localparam int BAD_W  = $clog2(BAD_MAX + 1);
    localparam int WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_WAIT,
        ST_CHECK,
        ST_LOCK
    } state_t;

    state_t              state_q, state_d;
    logic [GOOD_W-1:0]   good_q,  good_d;
    logic [WIN_W-1:0]    win_q,   win_d;
    logic [BAD_W-1:0]    bad_q,   bad_d;
    logic [WAIT_W-1:0]   wait_q,  wait_d;
    logic [POS_W-1:0]    pos_q,   pos_d;
    logic                slp_q,   slp_d;
    logic                err_q,   err_d;
    logic                vld_q,   vld_d;
    logic                lo_syn_q, lo_syn_d;
    logic [FW-3:0]       dat_q;
    logic [1:0]          sh_q;

    logic                sh_ok;
    logic                win_last;
    logic [POS_W-1:0]    pos_inc;

    // A valid header has exactly one bit set (01 or 10).
    assign sh_ok    = Rx_Phy_Dat[FW-1] ^ Rx_Phy_Dat[FW-2];
    assign win_last = (win_q == WIN_W'(SWT - 1));
    assign pos_inc  = (pos_q == POS_W'(FW - 1)) ? '0 : pos_q + POS_W'(1);

    always_comb begin
        // NOTE: every _d signal gets a default first, so no path can infer a latch.
        state_d = state_q;
        good_d  = good_q;
        win_d   = win_q;
        bad_d   = bad_q;
        wait_d  = wait_q;
        pos_d   = pos_q;
        slp_d   = 1'b0;
        err_d   = 1'b0;

        if (Rx_Re_Syn) begin
            // Forced resync: restart hunting in place, without slipping.
            state_d = ST_HUNT;
            good_d  = '0;
            win_d   = '0;
            bad_d   = '0;
            wait_d  = '0;
        end else begin
            unique case (state_q)
                ST_HUNT: begin
                    if (sh_ok) begin
                        good_d  = GOOD_W'(1);
                        state_d = (LOCK_CNT == 1) ? ST_LOCK : ST_CHECK;
                    end else begin
                        slp_d   = 1'b1;
                        pos_d   = pos_inc;
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The first WAIT cycle carries the slip pulse. SLIP_WAIT
                    // more cycles follow while the SERDES realigns. This keeps
                    // slips SLIP_WAIT+2 cycles apart.
                    if (wait_q == WAIT_W'(SLIP_WAIT)) begin
                        wait_d  = '0;
                        state_d = ST_HUNT;
                    end else begin
                        wait_d  = wait_q + WAIT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (sh_ok) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                            win_d   = '0;
                            bad_d   = '0;
                            state_d = ST_LOCK;
                        end
                    end else begin
                        err_d   = 1'b1;
                        slp_d   = 1'b1;
                        pos_d   = pos_inc;
                        good_d  = '0;
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end
                end
                ST_LOCK: begin
                    err_d = ~sh_ok;
                    win_d = win_last ? '0 : win_q + WIN_W'(1);
                    if (!sh_ok && (bad_q == BAD_W'(BAD_MAX - 1))) begin
                        // Loss takes precedence over a coincident window wrap.
                        slp_d   = 1'b1;
                        pos_d   = pos_inc;
                        good_d  = '0;
                        win_d   = '0;
                        bad_d   = '0;
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end else if (win_last) begin
                        bad_d = '0;
                    end else if (!sh_ok) begin
                        bad_d = bad_q + BAD_W'(1);
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // The word is valid only if it was taken in LOCK and did not end the lock.
        vld_d    = (state_q == ST_LOCK) && (state_d == ST_LOCK);
        lo_syn_d = (state_d != ST_LOCK);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Ck_77 or posedge Rs) begin
        if (Rs) begin
            state_q  <= ST_HUNT;
            good_q   <= '0;
            win_q    <= '0;
            bad_q    <= '0;
            wait_q   <= '0;
            pos_q    <= '0;
            slp_q    <= 1'b0;
            err_q    <= 1'b0;
            vld_q    <= 1'b0;
            lo_syn_q <= 1'b1;
            dat_q    <= '0;
            sh_q     <= '0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            win_q    <= win_d;
            bad_q    <= bad_d;
            wait_q   <= wait_d;
            pos_q    <= pos_d;
            slp_q    <= slp_d;
            err_q    <= err_d;
            vld_q    <= vld_d;
            lo_syn_q <= lo_syn_d;
            dat_q    <= Rx_Phy_Dat[FW-3:0];
            sh_q     <= Rx_Phy_Dat[FW-1:FW-2];
        end
    end

    assign Rx_Bit_Slp = slp_q;
    assign Rx_Dat     = dat_q;
    assign Rx_Dat_SH  = sh_q;
    assign Rx_Dat_Vld = vld_q;
    assign Rx_Lo_Syn  = lo_syn_q;
    assign Rx_Err_SH  = err_q;
    assign Rx_Slp_Pos = pos_q;

endmodule

// File: tb/tb_sici_rx_frame_sync.sv
// -----------------------------------------------------------------------------
// tb_sici_rx_frame_sync
//
// Directed bench for sici_rx_frame_sync with default parameters:
// FW=8, LOCK_CNT=64, SWT=64, BAD_MAX=16, SLIP_WAIT=4.
// Inputs change 1 ns after the rising edge, and outputs are read at the same point.
// -----------------------------------------------------------------------------
module tb_sici_rx_frame_sync;

    logic       Ck_77 = 1'b0;
    logic       Rs;
    logic [7:0] Rx_Phy_Dat;
    logic       Rx_Re_Syn;
    logic       Rx_Bit_Slp;
    logic [5:0] Rx_Dat;
    logic [1:0] Rx_Dat_SH;
    logic       Rx_Dat_Vld;
    logic       Rx_Lo_Syn;
    logic       Rx_Err_SH;
    logic [2:0] Rx_Slp_Pos;

    int n_checks = 0;
    int n_errors = 0;
    int slips    = 0;
    int errs     = 0;

    always #5 Ck_77 = ~Ck_77;

    sici_rx_frame_sync dut (
        .Ck_77      (Ck_77),
        .Rs         (Rs),
        .Rx_Phy_Dat (Rx_Phy_Dat),
        .Rx_Re_Syn  (Rx_Re_Syn),
        .Rx_Bit_Slp (Rx_Bit_Slp),
        .Rx_Dat     (Rx_Dat),
        .Rx_Dat_SH  (Rx_Dat_SH),
        .Rx_Dat_Vld (Rx_Dat_Vld),
        .Rx_Lo_Syn  (Rx_Lo_Syn),
        .Rx_Err_SH  (Rx_Err_SH),
        .Rx_Slp_Pos (Rx_Slp_Pos)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one word, let the DUT sample it, then tally the pulses it produced.
    task automatic step(input logic [7:0] w);
        Rx_Phy_Dat = w;
        @(posedge Ck_77);
        #1;
        if (Rx_Bit_Slp === 1'b1) slips++;
        if (Rx_Err_SH === 1'b1) errs++;
    endtask

    function automatic logic [5:0] pay(input int i);
        return 6'(i * 5 + 3);
    endfunction

    function automatic logic [7:0] good_w(input int i);
        return {2'b01, pay(i)};
    endfunction

    // Deserializer model: the transmitted words are {01, idx[2:0], 000}.
    // ofs is the bit offset into the serial stream. At offsets 5, 6 and 7 the
    // top two bits land on zeros, which gives an invalid SH.
    function automatic logic [7:0] rot_w(input int ofs, input int idx);
        logic [15:0] s;
        s = {2'b01, 3'(idx), 3'b000, 2'b01, 3'(idx + 1), 3'b000};
        return s[15 - ofs -: 8];
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_slp"},  Rx_Bit_Slp, 1'b0);
        check({tag, "_dat"},  Rx_Dat,     6'd0);
        check({tag, "_sh"},   Rx_Dat_SH,  2'd0);
        check({tag, "_vld"},  Rx_Dat_Vld, 1'b0);
        check({tag, "_los"},  Rx_Lo_Syn,  1'b1);
        check({tag, "_err"},  Rx_Err_SH,  1'b0);
        check({tag, "_pos"},  Rx_Slp_Pos, 3'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        int   ofs;
        int   idx;
        int   last_slip;
        int   lock_cyc;

        // ---------------- reset ----------------
        Rs         = 1'b1;
        Rx_Re_Syn  = 1'b0;
        Rx_Phy_Dat = 8'hFF;
        repeat (3) @(posedge Ck_77);
        #1;
        check_reset_vals("rst");
        Rs = 1'b0;

        // ---------------- aligned stream, lock entry ----------------
        slips = 0; errs = 0;
        for (int i = 1; i <= 64; i++) begin
            step(good_w(i));
            check("p1_dat", Rx_Dat, pay(i));
            if (i == 63) check("p1_los_w63", Rx_Lo_Syn, 1'b1);
        end
        check("p1_los_w64", Rx_Lo_Syn, 1'b0);
        check("p1_vld_w64", Rx_Dat_Vld, 1'b0);
        check("p1_sh_w64", Rx_Dat_SH, 2'b01);
        step(good_w(65));
        check("p1_vld_w65", Rx_Dat_Vld, 1'b1);
        check("p1_dat_w65", Rx_Dat, pay(65));
        check("p1_slips", slips, 0);
        check("p1_errs", errs, 0);
        check("p1_pos", Rx_Slp_Pos, 3'd0);

        // ---------------- LOCK monitoring windows ----------------
        // Word 65 was LOCK word j=0. Window 0 (j 0..63) gets 15 bad words at
        // j=2,6,..,58. Window 1 (j 64..127) gets 16 bad words at j=112..127, so
        // the 16th bad word is also the last word of its window.
        slips = 0; errs = 0;
        for (int j = 1; j < 128; j++) begin
            bad = (j < 64) ? ((j % 4 == 2) && (j <= 58)) : (j >= 112);
            step(bad ? {2'b00, 6'(j)} : good_w(j));
            if (j == 63) begin
                check("p2_errs_win0", errs, 15);
                check("p2_los_win0", Rx_Lo_Syn, 1'b0);
                check("p2_slips_win0", slips, 0);
            end
            if (j == 126) begin
                check("p2_los_bad15", Rx_Lo_Syn, 1'b0);
                check("p2_vld_bad15", Rx_Dat_Vld, 1'b1);
                check("p2_sh_bad15", Rx_Dat_SH, 2'b00);
            end
        end
        check("p2_los_loss", Rx_Lo_Syn, 1'b1);
        check("p2_vld_loss", Rx_Dat_Vld, 1'b0);
        check("p2_slp_loss", Rx_Bit_Slp, 1'b1);
        check("p2_err_loss", Rx_Err_SH, 1'b1);
        check("p2_pos_loss", Rx_Slp_Pos, 3'd1);
        check("p2_errs_total", errs, 31);
        check("p2_slips_total", slips, 1);

        // ---------------- WAIT ignores words; bad SH at CHECK word 63 ----------------
        slips = 0; errs = 0;
        step({2'b11, 6'h15});
        check("p3_slp_one_cycle", Rx_Bit_Slp, 1'b0);
        repeat (4) step({2'b11, 6'h15});
        check("p3_wait_errs", errs, 0);
        check("p3_wait_slips", slips, 0);
        for (int i = 1; i <= 62; i++) step(good_w(i));
        check("p3_los_w62", Rx_Lo_Syn, 1'b1);
        step({2'b00, 6'h3F});
        check("p3_err_w63", Rx_Err_SH, 1'b1);
        check("p3_slp_w63", Rx_Bit_Slp, 1'b1);
        check("p3_pos_w63", Rx_Slp_Pos, 3'd2);
        // The five good words below fall in WAIT and must not count toward lock.
        for (int i = 1; i <= 5; i++) step(good_w(i));
        for (int i = 1; i <= 64; i++) begin
            step(good_w(i));
            if (i == 63) check("p3_relock_w63", Rx_Lo_Syn, 1'b1);
        end
        check("p3_relock_w64", Rx_Lo_Syn, 1'b0);

        // ---------------- forced resync ----------------
        slips = 0;
        step(good_w(0));
        check("p4_vld_locked", Rx_Dat_Vld, 1'b1);
        Rx_Re_Syn = 1'b1;
        step(good_w(1));
        Rx_Re_Syn = 1'b0;
        check("p4_los_resync", Rx_Lo_Syn, 1'b1);
        check("p4_vld_resync", Rx_Dat_Vld, 1'b0);
        check("p4_slp_resync", Rx_Bit_Slp, 1'b0);
        check("p4_pos_resync", Rx_Slp_Pos, 3'd2);
        for (int i = 1; i <= 64; i++) begin
            step(good_w(i));
            if (i == 63) check("p4_relock_w63", Rx_Lo_Syn, 1'b1);
        end
        check("p4_relock_w64", Rx_Lo_Syn, 1'b0);
        // Resync held for 3 cycles: the block stays in HUNT, then needs 64 good words.
        Rx_Re_Syn = 1'b1;
        repeat (3) step(good_w(7));
        Rx_Re_Syn = 1'b0;
        check("p4_hold_los", Rx_Lo_Syn, 1'b1);
        for (int i = 1; i <= 64; i++) begin
            step(good_w(i));
            if (i == 63) check("p4_hold_w63", Rx_Lo_Syn, 1'b1);
        end
        check("p4_hold_w64", Rx_Lo_Syn, 1'b0);
        check("p4_slips", slips, 0);

        // ---------------- asynchronous reset while locked ----------------
        #2;
        Rs = 1'b1;
        #1;
        check_reset_vals("arst_lock");
        @(posedge Ck_77);
        #1;
        Rs = 1'b0;

        // ---------------- stream rotated by 3 bits, model honors slips ----------------
        // Expected: slips at cycles 1, 7 and 13. Alignment is reached at cycle 19,
        // and lock follows at cycle 19 + 63 = 82.
        slips = 0; ofs = 5; idx = 0; last_slip = -1; lock_cyc = -1;
        for (int c = 1; c <= 200 && lock_cyc < 0; c++) begin
            step(rot_w(ofs, idx));
            idx++;
            if (Rx_Bit_Slp === 1'b1) begin
                if (last_slip >= 0) check("p5_slip_gap_ge6", 32'((c - last_slip) >= 6), 1);
                last_slip = c;
                ofs = (ofs + 1) % 8;
            end
            if (Rx_Lo_Syn === 1'b0) lock_cyc = c;
        end
        check("p5_slips", slips, 3);
        check("p5_pos", Rx_Slp_Pos, 3'd3);
        check("p5_lock_cycle", lock_cyc, 82);
        check("p5_dat", Rx_Dat, {3'(idx - 1), 3'b000});

        // ---------------- persistent garbage, position wrap, reset mid-WAIT ----------------
        #2;
        Rs = 1'b1;
        @(posedge Ck_77);
        #1;
        Rs = 1'b0;
        slips = 0; errs = 0;
        for (int c = 1; c <= 300 && slips < 20; c++) begin
            step({2'b00, 6'h2A});
            if (Rx_Bit_Slp === 1'b1) begin
                if (slips == 7) check("p6_pos_slip7", Rx_Slp_Pos, 3'd7);
                if (slips == 8) check("p6_pos_wrap", Rx_Slp_Pos, 3'd0);
            end
        end
        check("p6_slips", slips, 20);
        check("p6_pos_20", Rx_Slp_Pos, 3'd4);
        check("p6_slp_live", Rx_Bit_Slp, 1'b1);
        check("p6_dat_live", Rx_Dat, 6'h2A);
        check("p6_errs_hunt", errs, 0);
        Rs = 1'b1;
        #1;
        check_reset_vals("arst_wait");
        @(posedge Ck_77);
        #1;
        Rs = 1'b0;
        step({2'b00, 6'h2A});
        check("p6_hunt_after_rst_slp", Rx_Bit_Slp, 1'b1);
        check("p6_hunt_after_rst_pos", Rx_Slp_Pos, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
